aes_decrypt_core: RTL and testbench

//  Iterative AES inverse cipher (FIPS-197, ECB), one round per clock; counterpart of the encrypt core.

---
 rtl/aes_decrypt_core.sv | 161 ++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - iterative AES inverse cipher (ECB), one round per clock
// Walks round keys from key[Nr] down to key[0], stalling whenever the requested subkey is not yet valid.
module aes_decrypt_core #(
    parameter int KEY_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [127:0]          ciphertext,
    input  logic [127:0]          subkey,
    input  logic                  subkey_valid,
    output logic [KEY_ADDR_W-1:0] subkey_addr,
    output logic [127:0]          plaintext,
    output logic                  plaintext_valid,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [127:0]          blk_q, blk_d;
    logic [3:0]            rounds_left_q, rounds_left_d;
    logic [KEY_ADDR_W-1:0] subkey_addr_q, subkey_addr_d;
    logic [127:0]          plaintext_q, plaintext_d;
    logic                  plaintext_valid_q, plaintext_valid_d;
    logic                  busy_q, busy_d;

    logic [3:0]            nr;
    logic [15:0][7:0]      st;
    logic [15:0][7:0]      inv_rs;
    logic [15:0][7:0]      keyed;
    logic [15:0][7:0]      mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by the field inverse computed as x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] x;
        logic [7:0] sq;
        logic [7:0] r;
        x  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        sq = x;
        r  = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Byte i of the block (column-major, row = i%4) lives at st[15-i].
    always_comb begin
        st = blk_q;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                inv_rs[15 - (4 * c + r)] = inv_sbox(st[15 - (4 * ((c - r + 4) % 4) + r)]);
            end
        end
        keyed = inv_rs ^ subkey;
        for (int c = 0; c < 4; c++) begin
            mixed[15 - 4 * c] = gf_mul(keyed[15 - 4 * c], 8'h0e) ^ gf_mul(keyed[14 - 4 * c], 8'h0b)
                              ^ gf_mul(keyed[13 - 4 * c], 8'h0d) ^ gf_mul(keyed[12 - 4 * c], 8'h09);
            mixed[14 - 4 * c] = gf_mul(keyed[15 - 4 * c], 8'h09) ^ gf_mul(keyed[14 - 4 * c], 8'h0e)
                              ^ gf_mul(keyed[13 - 4 * c], 8'h0b) ^ gf_mul(keyed[12 - 4 * c], 8'h0d);
            mixed[13 - 4 * c] = gf_mul(keyed[15 - 4 * c], 8'h0d) ^ gf_mul(keyed[14 - 4 * c], 8'h09)
                              ^ gf_mul(keyed[13 - 4 * c], 8'h0e) ^ gf_mul(keyed[12 - 4 * c], 8'h0b);
            mixed[12 - 4 * c] = gf_mul(keyed[15 - 4 * c], 8'h0b) ^ gf_mul(keyed[14 - 4 * c], 8'h0d)
                              ^ gf_mul(keyed[13 - 4 * c], 8'h09) ^ gf_mul(keyed[12 - 4 * c], 8'h0e);
        end
    end

    always_comb begin
        nr                = 4'd8 + {1'b0, key_len, 1'b0};
        fsm_d             = fsm_q;
        blk_d             = blk_q;
        rounds_left_d     = rounds_left_q;
        subkey_addr_d     = subkey_addr_q;
        plaintext_d       = plaintext_q;
        plaintext_valid_d = plaintext_valid_q;
        busy_d            = busy_q;
        case (fsm_q)
            IDLE: begin
                if (start && key_len != 2'd0) begin
                    blk_d             = ciphertext;
                    rounds_left_d     = nr;
                    subkey_addr_d     = KEY_ADDR_W'(nr);
                    plaintext_valid_d = 1'b0;
                    busy_d            = 1'b1;
                    fsm_d             = INIT;
                end
            end
            INIT: begin
                if (subkey_valid) begin
                    blk_d         = blk_q ^ subkey;
                    subkey_addr_d = subkey_addr_q - KEY_ADDR_W'(1);
                    fsm_d         = ROUND;
                end
            end
            ROUND: begin
                if (subkey_valid) begin
                    subkey_addr_d = subkey_addr_q - KEY_ADDR_W'(1);
                    rounds_left_d = rounds_left_q - 4'd1;
                    if (rounds_left_q > 4'd1) begin
                        blk_d = mixed;
                    end else begin
                        // Final round skips InvMixColumns; address wraps, which is harmless in IDLE.
                        plaintext_d       = keyed;
                        plaintext_valid_d = 1'b1;
                        busy_d            = 1'b0;
                        fsm_d             = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q             <= IDLE;
            blk_q             <= '0;
            rounds_left_q     <= '0;
            subkey_addr_q     <= '0;
            plaintext_q       <= '0;
            plaintext_valid_q <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            fsm_q             <= fsm_d;
            blk_q             <= blk_d;
            rounds_left_q     <= rounds_left_d;
            subkey_addr_q     <= subkey_addr_d;
            plaintext_q       <= plaintext_d;
            plaintext_valid_q <= plaintext_valid_d;
            busy_q            <= busy_d;
        end
    end

    assign subkey_addr     = subkey_addr_q;
    assign plaintext       = plaintext_q;
    assign plaintext_valid = plaintext_valid_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - self-checking bench for aes_decrypt_core
// Reference model: forward AES (S-box built by brute-force field inverse) plus key expansion feeding a key memory.
module tb_aes_decrypt_core;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   key_len;
    logic [127:0] ciphertext;
    logic [127:0] subkey;
    logic         subkey_valid;
    logic [3:0]   subkey_addr;
    logic [127:0] plaintext;
    logic         plaintext_valid;
    logic         busy;

    logic [127:0] rk [0:15];
    logic [7:0]   sbox [0:255];

    int checks = 0;
    int errors = 0;

    logic [127:0] res_pt;
    int           res_lat;
    int           res_stall;
    logic         res_addr_ok;
    logic         res_busy_ok;
    logic         res_hold_ok;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K_128   = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K_192   = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K_256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        logic [127:0] ct;
        logic [63:0]  mask;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    vec_t vt [4];

    aes_decrypt_core #(.KEY_ADDR_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .key_len         (key_len),
        .ciphertext      (ciphertext),
        .subkey          (subkey),
        .subkey_valid    (subkey_valid),
        .subkey_addr     (subkey_addr),
        .plaintext       (plaintext),
        .plaintext_valid (plaintext_valid),
        .busy            (busy)
    );

    assign subkey = rk[subkey_addr];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = 2 * kl + 2;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : 128'h0;
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4 * c + k];
                    s[4 * c]     = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4 * c + 1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    s[4 * c + 2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    s[4 * c + 3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge where plaintext_valid is seen.
    task automatic do_op(input logic [1:0] kl, input logic [127:0] ct, input logic [63:0] mask,
                         input int pulse_at);
        int         step;
        int         exp_addr;
        logic [3:0] held;
        logic       stalled;
        exp_addr    = 8 + 2 * kl;
        res_addr_ok = 1'b1;
        res_busy_ok = 1'b1;
        res_hold_ok = 1'b1;
        res_stall   = 0;
        key_len      = kl;
        ciphertext   = ct;
        start        = 1'b1;
        subkey_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        key_len    = 2'($urandom);
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        step = 0;
        while (!plaintext_valid && step < 400) begin
            if (!busy) res_busy_ok = 1'b0;
            start        = (step == pulse_at);
            subkey_valid = (step < 64) ? !mask[step] : 1'b1;
            held         = subkey_addr;
            stalled      = !subkey_valid;
            if (subkey_valid) begin
                if (int'(subkey_addr) != exp_addr) res_addr_ok = 1'b0;
                exp_addr--;
            end else begin
                res_stall++;
            end
            @(posedge clk);
            @(negedge clk);
            step++;
            if (stalled && subkey_addr != held) res_hold_ok = 1'b0;
        end
        res_lat = step;
        res_pt  = plaintext;
    endtask

    initial begin
        logic [1:0]   kl;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [63:0]  mask;
        int           n;

        reset        = 1'b0;
        start        = 1'b0;
        key_len      = 2'd0;
        ciphertext   = '0;
        subkey_valid = 1'b0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_sbox();

        vt[0] = '{kl: 2'd1, key: K_128, ct: CT_128, mask: 64'h0,    pt: PT_FIPS, lat: 11};
        vt[1] = '{kl: 2'd2, key: K_192, ct: CT_192, mask: 64'h0,    pt: PT_FIPS, lat: 13};
        vt[2] = '{kl: 2'd3, key: K_256, ct: CT_256, mask: 64'h0,    pt: PT_FIPS, lat: 15};
        vt[3] = '{kl: 2'd1, key: K_128, ct: CT_128, mask: 64'h1F07, pt: PT_FIPS, lat: 19};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", plaintext_valid, 1'b0);
        check("reset_pt", plaintext, 128'h0);
        check("reset_addr", subkey_addr, 4'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            expand(vt[v].key, vt[v].kl);
            do_op(vt[v].kl, vt[v].ct, vt[v].mask, -1);
            check($sformatf("vec%0d_pt", v), res_pt, vt[v].pt);
            check($sformatf("vec%0d_latency", v), res_lat, vt[v].lat);
            check($sformatf("vec%0d_addr_seq", v), res_addr_ok, 1'b1);
            check($sformatf("vec%0d_busy", v), res_busy_ok, 1'b1);
            check($sformatf("vec%0d_addr_hold", v), res_hold_ok, 1'b1);
        end

        // key_len=0 start is ignored; previous result stays visible
        key_len = 2'd0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("klen0_busy", busy, 1'b0);
        check("klen0_valid", plaintext_valid, 1'b1);
        check("klen0_pt", plaintext, PT_FIPS);

        // start pulsed mid-operation with garbage inputs
        expand(K_256, 2'd3);
        do_op(2'd3, CT_256, 64'h0, 6);
        check("pulse_pt", res_pt, PT_FIPS);
        check("pulse_latency", res_lat, 15);

        // start held across the completing edge, accepted on the following edge
        expand(K_128, 2'd1);
        do_op(2'd1, CT_128, 64'h0, 10);
        check("same_edge_pt", res_pt, PT_FIPS);
        check("same_edge_latency", res_lat, 11);
        check("same_edge_busy", busy, 1'b0);
        key_len    = 2'd1;
        ciphertext = CT_128;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("next_cycle_valid", plaintext_valid, 1'b0);
        check("next_cycle_busy", busy, 1'b1);
        n = 0;
        while (!plaintext_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("next_cycle_latency", n, 11);
        check("next_cycle_pt", plaintext, PT_FIPS);

        // asynchronous reset during round 5
        key_len    = 2'd1;
        ciphertext = CT_128;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", plaintext_valid, 1'b0);
        check("midrst_pt", plaintext, 128'h0);
        check("midrst_addr", subkey_addr, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(2'd1, CT_128, 64'h0, -1);
        check("post_rst_pt", res_pt, PT_FIPS);
        check("post_rst_latency", res_lat, 11);

        for (int i = 0; i < 1000; i++) begin
            kl  = 2'($urandom_range(1, 3));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key, kl);
            ct = encrypt(pt, 8 + 2 * kl);
            for (int b = 0; b < 64; b++) mask[b] = ($urandom_range(0, 3) == 0);
            do_op(kl, ct, mask, (i % 8 == 0) ? int'($urandom_range(1, 12)) : -1);
            check("rt_pt", res_pt, pt);
            check("rt_latency", res_lat, 9 + 2 * kl + res_stall);
            check("rt_addr_seq", res_addr_ok, 1'b1);
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
